// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path: func3 size codes, the
// mem_access_unit state encoding and small request-decoding helpers.
package riscv_pkg;

  // func3 load/store size codes
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Access FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mau_state_e;

  // A request is legal when func3 is a known size and the address is
  // naturally aligned for that size.
  function automatic logic ls_legal(input logic [2:0] func3, input logic [1:0] off);
    logic ok;
    case (func3)
      LS_B, LS_BU: ok = 1'b1;
      LS_H, LS_HU: ok = ~off[0];
      LS_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for a store; func3[1:0] carries the size for signed and
  // unsigned codes alike.
  function automatic logic [3:0] ls_be(input logic [2:0] func3, input logic [1:0] off);
    logic [3:0] be;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the enabled bytes carry it.
  function automatic logic [31:0] ls_wdata(input logic [2:0] func3, input logic [31:0] wdata);
    logic [31:0] rep;
    case (func3[1:0])
      2'b00:   rep = {4{wdata[7:0]}};
      2'b01:   rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the addressed byte/half/word out of a memory word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [31:0] lane;

  // Shift the addressed lane down to bit 0, then extend according to func3
  always_comb begin
    lane   = mem_rdata >> {off, 3'b000};
    result = lane;
    case (func3)
      LS_B:    result = {{24{lane[7]}}, lane[7:0]};
      LS_BU:   result = {24'h0, lane[7:0]};
      LS_H:    result = {{16{lane[15]}}, lane[15:0]};
      LS_HU:   result = {16'h0, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store port between the multicycle controller and the
// unified memory. IDLE->REQ->RESP FSM with a word-aligned req/ack handshake.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has not
// been acknowledged within TIMEOUT_CYCLES REQ cycles.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  mau_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  func3_q, func3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_result;
  logic        timeout_hit;

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .off       (off_q),
    .func3     (func3_q),
    .result    (load_result)
  );

  // Last REQ cycle allowed before the request is abandoned
  assign timeout_hit = TIMEOUT_EN && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Next-state logic: request latching, ack handling, load capture, timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    func3_d = func3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (ls_legal(req_func3, req_addr[1:0])) begin
            addr_d  = {req_addr[31:2], 2'b00};
            off_d   = req_addr[1:0];
            func3_d = req_func3;
            we_d    = req_write;
            be_d    = req_write ? ls_be(req_func3, req_addr[1:0]) : 4'b0000;
            wdata_d = ls_wdata(req_func3, req_wdata);
            err_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = ST_REQ;
          end else begin
            // Illegal requests never reach the memory
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = load_result;
          end
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset drops an in-flight request at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      off_q   <= 2'b00;
      func3_q <= 3'b000;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      func3_q <= func3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q & mem_req;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == ST_RESP);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign stall     = ((state_q == ST_IDLE) & req_valid) | (state_q == ST_REQ);

endmodule
